spi_sram_ctrl: RTL and testbench
================================

SPI_SRAM_CTRL -- requirements
Module: spi_sram_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the SCK half-period in HCLK cycles (legal range 1..255).
REQ-002 SHALL have port HCLK, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port HRESET, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports req0/req1, input, 1 each, transaction request per requester.
REQ-005 SHALL have ports we0/we1, input, 1 each, 1=write, 0=read.
REQ-006 SHALL have ports addr0/addr1, input, 16 each, SRAM byte address.
REQ-007 SHALL have ports wdata0/wdata1, input, 8 each, write byte.
REQ-008 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.
REQ-009 SHALL have port rdata, output, 8, last read byte.
REQ-010 SHALL have port busy, output, 1, high when the FSM is not in IDLE.
REQ-011 SHALL have ports sck (output, 1), mosi (output, 1), miso (input, 1) and csn (output, 1) as the SPI mode-0 pins to a 23LC512 SRAM.

Function
REQ-012 SHALL implement FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD and DONE.
REQ-013 SHALL, in IDLE with any req high, grant one requester and latch its we/addr/wdata at that edge (the grant edge); inputs are don't-care afterwards.
REQ-014 SHALL hold CS_SETUP for CLK_DIV cycles with csn=0 and sck=0.
REQ-015 SHALL shift a 32-bit frame in SHIFT, MSB first: command (8'h02 write, 8'h03 read), addr[15:0], then data (wdata for a write, 8'h00 for a read).
REQ-016 SHALL generate 32 SCK pulses, each CLK_DIV cycles low followed by CLK_DIV cycles high, for 64*CLK_DIV cycles in total.
REQ-017 SHALL change mosi only while sck is low and sample miso on each sck rising edge.
REQ-018 SHALL hold CS_HOLD for CLK_DIV cycles with sck=0 and csn=0, then raise csn on entry to DONE.
REQ-019 SHALL assert done for the granted requester for exactly one cycle, starting 66*CLK_DIV cycles after the grant edge.
REQ-020 SHALL keep DONE for CLK_DIV cycles with csn=1 as the minimum deselect gap, then return to IDLE.
REQ-021 SHALL load rdata from the last 8 miso samples on a read, valid from the done pulse; a write SHALL leave rdata unchanged.
REQ-022 SHALL hold requests arriving while busy until IDLE.
REQ-023 SHALL treat any req high in IDLE as a new request; a requester SHALL drop req after done to avoid re-issue.
REQ-024 SHALL complete a transaction whose req drops mid-transaction, including its done pulse.
REQ-025 SHALL use an 8-bit divider counter and a 6-bit SCK-edge counter, both wrapping to 0 at each state change.

Reset
REQ-026 SHALL, when HRESET is high at a rising edge, force IDLE with csn=1, sck=0, mosi=0, done0=done1=0, busy=0, rdata=8'h00 and the last-grant pointer at requester 1.
REQ-027 SHALL, on reset mid-transaction, abort the transaction with csn high on the next cycle and no done pulse.

Configuration
REQ-028 SHALL, with SPI_SRAM_CTRL_RR_EN defined, arbitrate round-robin: on simultaneous requests, grant the requester not served last (requester 0 first after reset).
REQ-029 SHALL, without SPI_SRAM_CTRL_RR_EN defined, use fixed priority with req0 always winning and no last-grant register.

Structure
REQ-030 SHALL take the state enum, CMD_READ=8'h03, CMD_WRITE=8'h02 and FRAME_BITS=32 from the shared package spi_sram_pkg.
REQ-031 SHALL implement arbitration in the sub-module spi_sram_arb (inputs req0/req1 and a grant-enable strobe; outputs a one-hot grant).

Verification (CLK_DIV=4, 23LC512 model on the pins)
REQ-032 SHALL cover: write addr0=16'h0010, wdata0=8'hA5 -> mosi frame 02_0010_A5, 32 SCK pulses, done0 pulse 264 cycles after grant.
REQ-033 SHALL cover: read addr1=16'h0010 after the write above -> mosi frame 03_0010_00, rdata=8'hA5 at the done1 pulse.
REQ-034 SHALL cover: req0 and req1 asserted in the same cycle, RR build -> requester 0 served, then requester 1; repeated -> requester 1 first; fixed build -> requester 0 both times.
REQ-035 SHALL cover: HRESET asserted at SCK edge 10 of a write -> csn=1, busy=0 next cycle, no done; a subsequent read of that address returns the old data.
REQ-036 SHALL cover: req1 raised while busy serving req0 -> req1 granted the cycle after DONE ends, csn high for at least 4 cycles between frames.
REQ-037 SHALL cover: req0 dropped at cycle 20 of a read -> the frame completes and done0 still pulses.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// -----------------------------------------------------------------------------
// spi_sram_pkg
//   Shared definitions for the SPI SRAM controller (23LC512, SPI mode 0):
//   controller state encoding, command opcodes, frame length and a helper
//   that assembles the 32-bit command/address/data frame.
// -----------------------------------------------------------------------------
package spi_sram_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam logic [7:0]  CMD_WRITE  = 8'h02;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Frame sent MSB first: opcode, 16-bit address, data byte (dummy on reads).
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic        we,
    input logic [15:0] addr,
    input logic [7:0]  wdata
  );
    build_frame = {(we ? CMD_WRITE : CMD_READ), addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_sram_arb.sv
// -----------------------------------------------------------------------------
// spi_sram_arb
//   Two-requester arbiter for the SPI SRAM controller.
//   Build option: SPI_SRAM_CTRL_RR_EN
//     defined   -> round-robin; on a tie the requester not served last wins,
//                  and the last-grant pointer resets to requester 1 so that
//                  requester 0 wins the first tie.
//     undefined -> fixed priority, req0 always wins, no state.
//
//   Ports
//     HCLK, HRESET : clock / synchronous active-high reset (round-robin only)
//     req0, req1   : request lines
//     grant_en     : strobe, high when the controller can accept a grant
//     grant[1:0]   : one-hot grant, all zero when grant_en is low
// -----------------------------------------------------------------------------
module spi_sram_arb (
`ifdef SPI_SRAM_CTRL_RR_EN
  input  logic       HCLK,
  input  logic       HRESET,
`endif
  input  logic       req0,
  input  logic       req1,
  input  logic       grant_en,
  output logic [1:0] grant
);

`ifdef SPI_SRAM_CTRL_RR_EN
  // 1 = requester 1 was granted most recently.
  logic last_q;
  logic last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (grant_en) begin
      if (req0 && req1) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
    if (grant != 2'b00) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/spi_sram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_sram_ctrl
//   Two-requester byte read/write controller for a 23LC512 SPI SRAM in
//   SPI mode 0. Each transaction is one 32-bit frame: opcode, address, data.
//   Build option: SPI_SRAM_CTRL_RR_EN selects round-robin arbitration
//   (see spi_sram_arb); otherwise req0 has fixed priority.
//
//   Parameter
//     CLK_DIV        : SCK half-period in HCLK cycles (1..255)
//   Ports
//     HCLK, HRESET   : clock / synchronous active-high reset
//     req*, we*, addr*, wdata* : per-requester request, direction, address, data
//     done0, done1   : one-cycle completion pulse to the served requester
//     rdata          : byte returned by the most recent read
//     busy           : controller not in IDLE
//     sck, mosi, miso, csn : SPI pins to the SRAM
//
//   Timeline from the grant edge (D = CLK_DIV):
//     CS_SETUP D cycles, SHIFT 64*D cycles, CS_HOLD D cycles, then DONE
//     (done pulses at 66*D) held D cycles with csn high before IDLE.
// -----------------------------------------------------------------------------
module spi_sram_ctrl
  import spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        csn
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] EDGE_LAST = 6'(2 * FRAME_BITS - 1);
  localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [7:0]              div_q, div_d;
  logic [5:0]              edge_q, edge_d;   // SCK half-period index in SHIFT
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    we_q, we_d;
  logic [1:0]              gnt_q, gnt_d;     // one-hot owner of the transaction
  logic [7:0]              rx_q, rx_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [1:0]              done_q, done_d;
  logic                    csn_q, csn_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;

  logic [1:0]              grant;
  logic                    grant_en;
  logic                    div_last;
  logic [4:0]              bit_idx;

  assign grant_en = (state_q == IDLE);
  assign div_last = (div_q == DIV_LAST);

  spi_sram_arb u_arb (
`ifdef SPI_SRAM_CTRL_RR_EN
    .HCLK     (HCLK),
    .HRESET   (HRESET),
`endif
    .req0     (req0),
    .req1     (req1),
    .grant_en (grant_en),
    .grant    (grant)
  );

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    frame_d = frame_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 2'b00;
    csn_d   = 1'b1;
    sck_d   = 1'b0;
    mosi_d  = 1'b0;
    bit_idx = 5'd0;

    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = CS_SETUP;
          gnt_d   = grant;
          if (grant[1]) begin
            we_d    = we1;
            frame_d = build_frame(we1, addr1, wdata1);
          end else begin
            we_d    = we0;
            frame_d = build_frame(we0, addr0, wdata0);
          end
        end
      end
      CS_SETUP: begin
        if (div_last) state_d = SHIFT;
      end
      SHIFT: begin
        // End of a low half: this edge raises SCK, so capture miso now.
        if (div_last && !edge_q[0]) begin
          rx_d = {rx_q[6:0], miso};
        end
        if (div_last && (edge_q == EDGE_LAST)) state_d = CS_HOLD;
      end
      CS_HOLD: begin
        if (div_last) begin
          state_d = DONE;
          done_d  = gnt_q;
          if (!we_q) rdata_d = rx_q;
        end
      end
      DONE: begin
        if (div_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Both counters restart on every state change.
    if (state_d != state_q) begin
      div_d  = 8'd0;
      edge_d = 6'd0;
    end else if (state_q != IDLE) begin
      if (div_last) begin
        div_d = 8'd0;
        if (state_q == SHIFT) edge_d = edge_q + 6'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    // Pins are registered from the next state, so they line up with it.
    // Odd half-periods are SCK high; the data bit only advances when a new
    // low half starts, which keeps mosi stable across each rising edge.
    csn_d   = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
    sck_d   = (state_d == SHIFT) && edge_d[0];
    bit_idx = LAST_BIT - edge_d[5:1];
    if (state_d == CS_SETUP) begin
      mosi_d = frame_d[FRAME_BITS-1];
    end else if (state_d == SHIFT) begin
      mosi_d = frame_d[bit_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      edge_q  <= 6'd0;
      gnt_q   <= 2'b00;
      rdata_q <= 8'h00;
      done_q  <= 2'b00;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  // NOTE: the frame, direction and receive shifter have no reset: each is
  // loaded at the grant or during SHIFT before anything reads it.
  always_ff @(posedge HCLK) begin
    frame_q <= frame_d;
    we_q    <= we_d;
    rx_q    <= rx_d;
  end

  assign done0 = done_q[0];
  assign done1 = done_q[1];
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);
  assign csn   = csn_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_sram_ctrl
//   Self-checking bench for spi_sram_ctrl with CLK_DIV=4 and a behavioural
//   23LC512 on the SPI pins. Expected completions are queued when a request
//   is driven and compared when the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_spi_sram_ctrl;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 66 * CLK_DIV;
  localparam int BUDGET  = LAT + 40;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        done0, done1, busy, sck, mosi, csn;
  logic [7:0]  rdata;
  logic        miso = 1'b0;

  always #5 HCLK = ~HCLK;

  spi_sram_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .done0  (done0),
    .done1  (done1),
    .rdata  (rdata),
    .busy   (busy),
    .sck    (sck),
    .mosi   (mosi),
    .miso   (miso),
    .csn    (csn)
  );

  // ---------------- 23LC512 model ----------------
  logic [7:0]  mem [0:65535];
  int          bit_cnt = 0;
  logic [31:0] frame_rx = '0;
  logic [7:0]  cmd_rx = '0;
  logic [7:0]  rd_byte = '0;
  logic [31:0] last_frame = '0;
  int          last_pulses = 0;

  always @(posedge sck or negedge csn) begin
    if (sck === 1'b0) begin
      bit_cnt  = 0;
      frame_rx = '0;
    end else if (csn === 1'b0) begin
      frame_rx = {frame_rx[30:0], mosi};
      bit_cnt++;
      if (bit_cnt == 8)  cmd_rx = frame_rx[7:0];
      if (bit_cnt == 24) rd_byte = mem[frame_rx[15:0]];
      if (bit_cnt == 32 && frame_rx[31:24] == 8'h02) mem[frame_rx[23:8]] = frame_rx[7:0];
    end
  end

  always @(negedge sck or posedge csn) begin
    if (csn === 1'b1) begin
      miso        = 1'b0;
      last_frame  = frame_rx;
      last_pulses = bit_cnt;
    end else if (cmd_rx == 8'h03 && bit_cnt >= 24 && bit_cnt < 32) begin
      miso = rd_byte[31 - bit_cnt];
    end
  end

  // ---------------- pin monitor (samples 1 time unit after each edge) ----------------
  int   cyc = 0, grant_cyc = 0, rise_cyc = 0, last_gap = 0, mosi_viol = 0;
  logic sck_p = 1'b0, mosi_p = 1'b0, csn_p = 1'b1;

  always @(posedge HCLK) begin
    #1;
    cyc++;
    if (csn_p === 1'b1 && csn === 1'b0) begin
      grant_cyc = cyc;
      last_gap  = cyc - rise_cyc;
    end
    if (csn_p === 1'b0 && csn === 1'b1) rise_cyc = cyc;
    if (sck === 1'b1 && mosi !== mosi_p) mosi_viol++;
    sck_p  = sck;
    mosi_p = mosi;
    csn_p  = csn;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          who;
    logic [31:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_rdata = 8'h00;
  int         last_done_cyc = 0;

  task automatic tick();
    @(posedge HCLK);
    #2;
  endtask

  task automatic issue(input int who, input logic we, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] exp_rd);
    exp_t e;
    e.who   = who;
    e.frame = {(we ? 8'h02 : 8'h03), a, (we ? wd : 8'h00)};
    if (!we) model_rdata = exp_rd;
    e.rdata = model_rdata;
    sb.push_back(e);
    if (who == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic expect_done(input int budget);
    exp_t e;
    int   who_act;
    bit   seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done0 === 1'b1 || done1 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done pulse within %0d cycles, %0d completions outstanding", budget, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    case ({done1, done0})
      2'b01:   who_act = 0;
      2'b10:   who_act = 1;
      default: who_act = 9;
    endcase
    if (who_act != e.who) begin
      errors++;
      $display("FAIL done_requester: got %0d (done1,done0=%b%b) expected %0d", who_act, done1, done0, e.who);
    end
    checks++;
    if (cyc - grant_cyc != LAT) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles after grant expected %0d", cyc - grant_cyc, LAT);
    end
    checks++;
    if (last_frame !== e.frame) begin
      errors++;
      $display("FAIL mosi_frame: got %08h expected %08h", last_frame, e.frame);
    end
    checks++;
    if (last_pulses != 32) begin
      errors++;
      $display("FAIL sck_pulses: got %0d expected 32", last_pulses);
    end
    checks++;
    if (rdata !== e.rdata) begin
      errors++;
      $display("FAIL rdata: got %02h expected %02h", rdata, e.rdata);
    end
    last_done_cyc = cyc;
    if (e.who == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
    checks++;
    if ({done1, done0} !== 2'b00) begin
      errors++;
      $display("FAIL done_width: got %b%b one cycle later expected 00", done1, done0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) tick();
    checks++; if (csn !== 1'b1)  begin errors++; $display("FAIL reset_csn: got %b expected 1", csn); end
    checks++; if (sck !== 1'b0)  begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if ({done1, done0} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b%b expected 00", done1, done0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
    HRESET = 1'b0;
    model_rdata = 8'h00;
    tick();
  endtask

  task automatic test_write();
    issue(0, 1'b1, 16'h0010, 8'hA5, 8'h00);
    expect_done(BUDGET);
    checks++;
    if (mosi_viol != 0) begin
      errors++;
      $display("FAIL mosi_stable: mosi changed while sck high %0d times expected 0", mosi_viol);
    end
  endtask

  task automatic test_read();
    issue(1, 1'b0, 16'h0010, 8'h00, 8'hA5);
    expect_done(BUDGET);
  endtask

  task automatic test_arbitration();
    HRESET = 1'b1; tick(); HRESET = 1'b0; tick();
    model_rdata = 8'h00;
    // Fresh reset: both builds serve requester 0 first, requester 1 waits.
    issue(0, 1'b1, 16'h0100, 8'h11, 8'h00);
    issue(1, 1'b1, 16'h0200, 8'h22, 8'h00);
    expect_done(BUDGET);
    expect_done(BUDGET);
    // Requester 0 served alone, so it is the last one served.
    issue(0, 1'b0, 16'h0100, 8'h00, 8'h11);
    expect_done(BUDGET);
`ifdef SPI_SRAM_CTRL_RR_EN
    issue(1, 1'b0, 16'h0200, 8'h00, 8'h22);
    issue(0, 1'b0, 16'h0100, 8'h00, 8'h11);
`else
    issue(0, 1'b0, 16'h0100, 8'h00, 8'h11);
    issue(1, 1'b0, 16'h0200, 8'h00, 8'h22);
`endif
    expect_done(BUDGET);
    expect_done(BUDGET);
  endtask

  task automatic test_reset_mid();
    bit reached = 1'b0;
    int dones = 0;
    issue(0, 1'b1, 16'h0020, 8'h5A, 8'h00);
    expect_done(BUDGET);
    repeat (CLK_DIV + 2) tick();
    // Overwrite attempt that gets aborted: not queued, no completion expected.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 8'hC3;
    tick();
    for (int i = 0; i < 200; i++) begin
      if (bit_cnt >= 10) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL abort_reach_edge10: sck rising edges %0d expected 10 within 200 cycles", bit_cnt);
    end
    HRESET = 1'b1;
    req0   = 1'b0;
    tick();
    HRESET = 1'b0;
    model_rdata = 8'h00;
    checks++; if (csn !== 1'b1)  begin errors++; $display("FAIL abort_csn: got %b expected 1", csn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (sck !== 1'b0)  begin errors++; $display("FAIL abort_sck: got %b expected 0", sck); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata: got %02h expected 00", rdata); end
    for (int i = 0; i < LAT + 20; i++) begin
      if (done0 === 1'b1 || done1 === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done cycles expected 0", dones);
    end
    issue(0, 1'b0, 16'h0020, 8'h00, 8'h5A);
    expect_done(BUDGET);
  endtask

  task automatic test_back_to_back();
    int d0;
    issue(0, 1'b1, 16'h0300, 8'h77, 8'h00);
    repeat (50) tick();
    issue(1, 1'b0, 16'h0300, 8'h00, 8'h77);
    expect_done(BUDGET);
    d0 = last_done_cyc;
    expect_done(BUDGET + CLK_DIV + 10);
    checks++;
    if (grant_cyc - d0 != CLK_DIV + 1) begin
      errors++;
      $display("FAIL b2b_grant: second grant %0d cycles after done0 expected %0d", grant_cyc - d0, CLK_DIV + 1);
    end
    checks++;
    if (last_gap < 4) begin
      errors++;
      $display("FAIL b2b_csn_gap: csn high %0d cycles expected at least 4", last_gap);
    end
  endtask

  task automatic test_drop();
    issue(0, 1'b0, 16'h0010, 8'h00, 8'hA5);
    tick();
    repeat (19) tick();
    req0 = 1'b0; we0 = 1'b1; addr0 = 16'hFFFF; wdata0 = 8'hEE;
    expect_done(BUDGET);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    test_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
